// File: rtl/hazard_detection_unit.sv
// Decode-stage hazard controller: stalls on load-use and multi-cycle MEM sequences, flushes on taken branches.
// Control lines are combinational from the current state; Afterbubble is IDEXFlush delayed by one cycle.
module hazard_detection_unit #(
   parameter int REG_W = 4,
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] IDRegsrc,
   input  logic [REG_W-1:0] IDRegdest,
   input  logic             IDUseSrc,
   input  logic             IDUseDest,
   input  logic [REG_W-1:0] EXRegdest,
   input  logic             EXMemRead,
   input  logic             EXBranchTaken,
   input  logic             MEMMultiStart,
   input  logic [CNT_W-1:0] MEMMultiLen,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IFIDFlush,
   output logic             IDEXFlush,
   output logic             Afterbubble
);

   typedef enum logic [1:0] {RUN, LOADSTALL, MEMBUSY} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] start_cnt;
   logic             load_use;

   assign load_use = EXMemRead &&
                     ((IDUseSrc  && (IDRegsrc  == EXRegdest)) ||
                      (IDUseDest && (IDRegdest == EXRegdest)));

   // A zero length behaves like a one-cycle sequence.
   assign start_cnt = (MEMMultiLen == '0) ? '0 : MEMMultiLen - 1'b1;

   always_comb begin
      PCWrite   = 1'b1;
      IFIDWrite = 1'b1;
      IFIDFlush = 1'b0;
      IDEXFlush = 1'b0;
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         RUN, LOADSTALL: begin
            state_nxt = RUN;
            if (MEMMultiStart) begin
               PCWrite   = EXBranchTaken;
               IFIDWrite = 1'b0;
               IFIDFlush = EXBranchTaken;
               IDEXFlush = 1'b1;
               cnt_nxt   = start_cnt;
               state_nxt = (start_cnt == '0) ? RUN : MEMBUSY;
            end else if (EXBranchTaken) begin
               IFIDFlush = 1'b1;
               IDEXFlush = 1'b1;
            end else if (state == RUN && load_use) begin
               PCWrite   = 1'b0;
               IFIDWrite = 1'b0;
               IDEXFlush = 1'b1;
               state_nxt = LOADSTALL;
            end
         end
         MEMBUSY: begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
            cnt_nxt   = cnt - 1'b1;
            // Leaving on cnt==0 too keeps a corrupted counter from wedging the pipe.
            if (cnt <= 1) state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
      if (!rst_n) begin
         PCWrite   = 1'b0;
         IFIDWrite = 1'b0;
         IFIDFlush = 1'b1;
         IDEXFlush = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         cnt         <= '0;
         Afterbubble <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         Afterbubble <= IDEXFlush;
      end
   end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench: expected control vectors {PCWrite,IFIDWrite,IFIDFlush,IDEXFlush,Afterbubble} are queued per step and checked at the falling edge.
module tb_hazard_detection_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] IDRegsrc, IDRegdest, EXRegdest;
   logic       IDUseSrc, IDUseDest, EXMemRead, EXBranchTaken, MEMMultiStart;
   logic [1:0] MEMMultiLen;
   logic       PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, Afterbubble;

   typedef struct {
      string      tag;
      logic [4:0] v;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   passes = 0;

   hazard_detection_unit #(.REG_W(4), .CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .IDRegsrc(IDRegsrc), .IDRegdest(IDRegdest),
      .IDUseSrc(IDUseSrc), .IDUseDest(IDUseDest),
      .EXRegdest(EXRegdest), .EXMemRead(EXMemRead),
      .EXBranchTaken(EXBranchTaken), .MEMMultiStart(MEMMultiStart),
      .MEMMultiLen(MEMMultiLen),
      .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
      .IDEXFlush(IDEXFlush), .Afterbubble(Afterbubble)
   );

   always #5 clk = ~clk;

   task automatic set_in(input logic [3:0] src, input logic [3:0] dst, input logic us,
                         input logic ud, input logic [3:0] exd, input logic mr,
                         input logic br, input logic ms, input logic [1:0] ml);
      IDRegsrc = src; IDRegdest = dst; IDUseSrc = us; IDUseDest = ud;
      EXRegdest = exd; EXMemRead = mr; EXBranchTaken = br;
      MEMMultiStart = ms; MEMMultiLen = ml;
   endtask

   task automatic push_exp(input string tag, input logic [4:0] v);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      q.push_back(e);
   endtask

   task automatic check_out();
      exp_t       e;
      logic [4:0] obs;
      e   = q.pop_front();
      obs = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, Afterbubble};
      checks++;
      assert (obs === e.v) passes++;
      else $error("FAIL %s: got pcw/ifw/iff/idf/ab=%b expected %b", e.tag, obs, e.v);
   endtask

   // One clock cycle: drive after the rising edge, compare at the falling edge.
   task automatic step(input string tag, input logic [4:0] v);
      push_exp(tag, v);
      @(negedge clk);
      check_out();
      @(posedge clk);
      #1;
   endtask

   initial begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      push_exp("reset_hold", 5'b00110);
      check_out();
      @(negedge clk);
      push_exp("reset_hold_edge", 5'b00110);
      check_out();
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      step("idle_after_reset", 5'b11000);

      set_in(3, 0, 1, 0, 3, 1, 0, 0, 0);
      step("load_use_src",     5'b00010);
      step("loadstall_ignore", 5'b11001);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("after_loadstall",  5'b11000);

      set_in(3, 3, 0, 0, 3, 1, 0, 0, 0);
      step("masked_operands",  5'b11000);
      set_in(3, 3, 0, 1, 3, 1, 0, 0, 0);
      step("load_use_dest",    5'b00010);
      set_in(3, 3, 0, 1, 3, 1, 1, 0, 0);
      step("loadstall_branch", 5'b11111);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("idle_after_flush", 5'b11001);

      set_in(11, 0, 1, 0, 3, 1, 0, 0, 0);
      step("full_width_cmp",   5'b11000);
      set_in(3, 0, 1, 0, 3, 1, 1, 0, 0);
      step("branch_over_lu",   5'b11110);
      set_in(3, 0, 1, 0, 3, 1, 0, 0, 0);
      step("still_run_lu",     5'b00011);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("lu_recover",       5'b11001);
      step("idle_a",           5'b11000);

      set_in(0, 0, 0, 0, 0, 0, 0, 1, 3);
      step("mem3_c1",          5'b00010);
      set_in(3, 0, 1, 0, 3, 1, 1, 1, 1);
      step("mem3_c2_ignore",   5'b00011);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("mem3_c3",          5'b00011);
      step("mem3_done",        5'b11001);
      step("mem3_quiet",       5'b11000);

      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step("mem0_stall",       5'b00010);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("mem0_done",        5'b11001);

      set_in(0, 0, 0, 0, 0, 0, 1, 1, 2);
      step("combo_c1",         5'b10110);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("combo_c2",         5'b00011);
      step("combo_c3",         5'b11001);
      step("combo_quiet",      5'b11000);

      set_in(0, 0, 0, 0, 0, 0, 0, 1, 3);
      step("rst_mem_c1",       5'b00010);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      push_exp("rst_mem_c2_pre", 5'b00011);
      #1;
      check_out();
      rst_n = 1'b0;
      #1;
      push_exp("rst_async_clear", 5'b00110);
      check_out();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step("post_rst_default", 5'b11000);
      step("post_rst_no_tail", 5'b11000);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
